// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional FP_MULTICYCLE_EN)
module pipeline_hazard_ctrl #(
  parameter int FP_LATENCY  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             dec_regA,
  input  logic [4:0]             dec_regB,
  input  logic                   dec_uses_regB,
  input  logic                   alu_valid,
  input  logic                   alu_MEM_R_EN,
  input  logic [4:0]             alu_regD,
  input  logic                   alu_is_float,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   EN_REG_FETCH,
  output logic                   EN_REG_DECODE,
  output logic                   EN_REG_ALU,
  output logic                   EN_REG_MEM,
  output logic                   bubble_decode,
  output logic                   bubble_alu,
  output logic                   bubble_mem,
  output logic [1:0]             ctrl_state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FP_BUSY  = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;

  logic mem_stall;
  logic load_use;
  logic fp_start;

  logic en_fetch, en_decode, en_alu, en_mem;
  logic bub_dec, bub_alu, bub_mem;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = alu_valid & alu_MEM_R_EN & (alu_regD != 5'd0) &
                     ((alu_regD == dec_regA) | (dec_uses_regB & (alu_regD == dec_regB)));

`ifdef FP_MULTICYCLE_EN
  // fp_cnt counts the remaining ALU-occupancy cycles after the start cycle
  localparam logic [3:0] FP_INIT = (FP_LATENCY > 1) ? 4'(FP_LATENCY - 2) : 4'd0;
  logic [3:0] fp_cnt_q, fp_cnt_d;
  assign fp_start = alu_valid & alu_is_float & (FP_LATENCY > 1);
`else
  // float ops complete in one ALU cycle; the input and latency are don't-cares
  logic unused_fp;
  assign unused_fp = alu_is_float ^ (FP_LATENCY > 1);
  assign fp_start  = 1'b0;
`endif

  // Hazard arbitration: mem_stall > FP occupancy > branch > load-use
  always_comb begin
    en_fetch  = 1'b1;
    en_decode = 1'b1;
    en_alu    = 1'b1;
    en_mem    = 1'b1;
    bub_dec   = 1'b0;
    bub_alu   = 1'b0;
    bub_mem   = 1'b0;
    state_d   = state_q;
`ifdef FP_MULTICYCLE_EN
    fp_cnt_d  = fp_cnt_q;
`endif
    if (mem_stall) begin
      en_fetch  = 1'b0;
      en_decode = 1'b0;
      en_alu    = 1'b0;
      en_mem    = 1'b0;
      if (state_q == ST_RUN) state_d = ST_MEM_WAIT;
`ifdef FP_MULTICYCLE_EN
      // the float unit keeps computing while memory holds the pipe
      if (fp_cnt_q != 4'd0) fp_cnt_d = fp_cnt_q - 4'd1;
`endif
    end
`ifdef FP_MULTICYCLE_EN
    else if (state_q == ST_FP_BUSY) begin
      if (fp_cnt_q != 4'd0) begin
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        en_alu    = 1'b0;
        bub_mem   = 1'b1;
        fp_cnt_d  = fp_cnt_q - 4'd1;
      end else begin
        state_d = ST_RUN;
      end
    end
`endif
    else begin
      // RUN, or the MEM_WAIT cycle in which memory completes
      state_d = ST_RUN;
      if (fp_start) begin
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        en_alu    = 1'b0;
        bub_mem   = 1'b1;
`ifdef FP_MULTICYCLE_EN
        state_d   = ST_FP_BUSY;
        fp_cnt_d  = FP_INIT;
`endif
      end else if (branch_taken) begin
        bub_dec = 1'b1;
        bub_alu = 1'b1;
      end else if (load_use) begin
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        bub_alu   = 1'b1;
      end
    end
    // reset forces a free-running pipe regardless of inputs
    if (reset) begin
      en_fetch  = 1'b1;
      en_decode = 1'b1;
      en_alu    = 1'b1;
      en_mem    = 1'b1;
      bub_dec   = 1'b0;
      bub_alu   = 1'b0;
      bub_mem   = 1'b0;
    end
  end

  // Saturating count of cycles the fetch stage is held
  always_comb begin
    stall_d = stall_q;
    if (!en_fetch && !(&stall_q)) stall_d = stall_q + STALL_ONE;
  end

  // Sequencer state and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      stall_q  <= '0;
`ifdef FP_MULTICYCLE_EN
      fp_cnt_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
`ifdef FP_MULTICYCLE_EN
      fp_cnt_q <= fp_cnt_d;
`endif
    end
  end

  assign EN_REG_FETCH  = en_fetch;
  assign EN_REG_DECODE = en_decode;
  assign EN_REG_ALU    = en_alu;
  assign EN_REG_MEM    = en_mem;
  assign bubble_decode = bub_dec;
  assign bubble_alu    = bub_alu;
  assign bubble_mem    = bub_mem;
  assign ctrl_state    = state_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] dec_regA, dec_regB, alu_regD;
  logic dec_uses_regB, alu_valid, alu_MEM_R_EN, alu_is_float;
  logic branch_taken, mem_req, mem_ready;
  logic en_f, en_d, en_a, en_m, b_d, b_a, b_m;
  logic [1:0] st;
  logic [15:0] sc;
  logic en_f3, en_d3, en_a3, en_m3, b_d3, b_a3, b_m3;
  logic [1:0] st3;
  logic [2:0] sc3;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FP_LATENCY(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dec_regA(dec_regA), .dec_regB(dec_regB),
    .dec_uses_regB(dec_uses_regB), .alu_valid(alu_valid), .alu_MEM_R_EN(alu_MEM_R_EN),
    .alu_regD(alu_regD), .alu_is_float(alu_is_float), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .EN_REG_FETCH(en_f), .EN_REG_DECODE(en_d), .EN_REG_ALU(en_a), .EN_REG_MEM(en_m),
    .bubble_decode(b_d), .bubble_alu(b_a), .bubble_mem(b_m),
    .ctrl_state(st), .stall_cycles(sc)
  );

  pipeline_hazard_ctrl #(.FP_LATENCY(4), .STALL_CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .dec_regA(dec_regA), .dec_regB(dec_regB),
    .dec_uses_regB(dec_uses_regB), .alu_valid(alu_valid), .alu_MEM_R_EN(alu_MEM_R_EN),
    .alu_regD(alu_regD), .alu_is_float(alu_is_float), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .EN_REG_FETCH(en_f3), .EN_REG_DECODE(en_d3), .EN_REG_ALU(en_a3), .EN_REG_MEM(en_m3),
    .bubble_decode(b_d3), .bubble_alu(b_a3), .bubble_mem(b_m3),
    .ctrl_state(st3), .stall_cycles(sc3)
  );

  // {EN_FETCH, EN_DECODE, EN_ALU, EN_MEM, bubble_decode, bubble_alu, bubble_mem}
  localparam logic [6:0] ALL = 7'b1111_000;
  localparam logic [6:0] MS  = 7'b0000_000;
  localparam logic [6:0] LU  = 7'b0011_010;
  localparam logic [6:0] BR  = 7'b1111_110;
  localparam logic [6:0] FP  = 7'b0001_001;

  typedef struct {
    logic [6:0]  eb;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        chk3;
    logic [2:0]  sc3;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic stim_done = 1'b0;

  task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic ub,
                       input logic v, input logic mr, input logic [4:0] rd,
                       input logic f, input logic br, input logic mq, input logic my);
    dec_regA = ra; dec_regB = rb; dec_uses_regB = ub; alu_valid = v;
    alu_MEM_R_EN = mr; alu_regD = rd; alu_is_float = f; branch_taken = br;
    mem_req = mq; mem_ready = my;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc3(input logic [6:0] eb, input logic [1:0] s, input logic [15:0] c,
                      input logic chk, input logic [2:0] c3, input string nm);
    exp_t e;
    e.eb = eb; e.st = s; e.sc = c; e.chk3 = chk; e.sc3 = c3; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [6:0] eb, input logic [1:0] s, input logic [15:0] c,
                     input string nm);
    cyc3(eb, s, c, 1'b0, 3'd0, nm);
  endtask

  // Monitor: pop one expectation per cycle and compare away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if ({en_f, en_d, en_a, en_m, b_d, b_a, b_m} !== e.eb) begin
        n_fail++;
        $display("FAIL %s enables/bubbles: got %b want %b", e.name,
                 {en_f, en_d, en_a, en_m, b_d, b_a, b_m}, e.eb);
      end
      n_checks++;
      if (st !== e.st) begin
        n_fail++;
        $display("FAIL %s ctrl_state: got %b want %b", e.name, st, e.st);
      end
      n_checks++;
      if (sc !== e.sc) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d want %0d", e.name, sc, e.sc);
      end
      if (e.chk3) begin
        n_checks++;
        if (sc3 !== e.sc3) begin
          n_fail++;
          $display("FAIL %s stall_cycles_sat: got %0d want %0d", e.name, sc3, e.sc3);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // reset overrides a pending memory stall
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(ALL, 2'b00, 16'd0, "reset_hold0");
    cyc(ALL, 2'b00, 16'd0, "reset_hold1");
    reset = 1'b0;
    idle();
    cyc(ALL, 2'b00, 16'd0, "idle");
    // load-use on RegA, then one bubble only
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(LU, 2'b00, 16'd0, "load_use_regA");
    idle();
    cyc(ALL, 2'b00, 16'd1, "after_load_use");
    // load-use on RegB
    drive(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(LU, 2'b00, 16'd1, "load_use_regB");
    drive(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ALL, 2'b00, 16'd2, "regB_not_used");
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ALL, 2'b00, 16'd2, "load_r0");
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ALL, 2'b00, 16'd2, "non_load_dep");
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ALL, 2'b00, 16'd2, "invalid_load");
    // branch wins over load-use
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(BR, 2'b00, 16'd2, "branch_over_load_use");
    idle();
    cyc(ALL, 2'b00, 16'd2, "after_branch");
    // five cycles of memory wait then release
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(MS, 2'b00, 16'd2, "mem_wait1");
    cyc(MS, 2'b10, 16'd3, "mem_wait2");
    cyc(MS, 2'b10, 16'd4, "mem_wait3");
    cyc(MS, 2'b10, 16'd5, "mem_wait4");
    cyc(MS, 2'b10, 16'd6, "mem_wait5");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(ALL, 2'b10, 16'd7, "mem_ready");
    idle();
    cyc(ALL, 2'b00, 16'd7, "after_mem");
`ifdef FP_MULTICYCLE_EN
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(FP, 2'b00, 16'd7, "fp_start");
    cyc(FP, 2'b01, 16'd8, "fp_busy2");
    cyc(FP, 2'b01, 16'd9, "fp_busy1");
    cyc(ALL, 2'b01, 16'd10, "fp_release");
    idle();
    cyc(ALL, 2'b00, 16'd10, "after_fp");
    // memory stall overlapping the float occupancy extends it by one cycle
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(FP, 2'b00, 16'd10, "fpm_start");
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(MS, 2'b01, 16'd11, "fpm_mem1");
    cyc(MS, 2'b01, 16'd12, "fpm_mem2");
    cyc(MS, 2'b01, 16'd13, "fpm_mem3");
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(ALL, 2'b01, 16'd14, "fpm_release");
    idle();
    cyc(ALL, 2'b00, 16'd14, "after_fpm");
    // reset while FP_BUSY with two cycles left
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(FP, 2'b00, 16'd14, "fpr_start");
    reset = 1'b1;
    cyc(ALL, 2'b00, 16'd0, "fpr_reset0");
    cyc(ALL, 2'b00, 16'd0, "fpr_reset1");
    reset = 1'b0;
    idle();
    cyc(ALL, 2'b00, 16'd0, "fpr_after");
    b = 16'd0;
`else
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ALL, 2'b00, 16'd7, "fp_single_cycle");
    idle();
    cyc(ALL, 2'b00, 16'd7, "after_fp");
    b = 16'd7;
`endif
    // reset while MEM_WAIT
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(MS, 2'b00, b, "mwr_stall1");
    cyc(MS, 2'b10, b + 16'd1, "mwr_stall2");
    reset = 1'b1;
    cyc(ALL, 2'b00, 16'd0, "mwr_reset0");
    cyc(ALL, 2'b00, 16'd0, "mwr_reset1");
    reset = 1'b0;
    idle();
    cyc(ALL, 2'b00, 16'd0, "mwr_after");
    // saturation of a 3-bit counter alongside the 16-bit one
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc3(MS, (i == 0) ? 2'b00 : 2'b10, 16'(i), 1'b1, (i > 7) ? 3'd7 : 3'(i), "sat_stall");
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc3(ALL, 2'b10, 16'd10, 1'b1, 3'd7, "sat_release");
    idle();
    cyc3(ALL, 2'b00, 16'd10, 1'b1, 3'd7, "sat_hold");
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage integer/float pipeline. Consumes decode-stage register fields, ALU-stage control bits and memory handshake, and drives the pipeline-register enables (EN_REG_FETCH/DECODE/ALU/MEM) plus bubble-insert strobes. Handles load-use interlock, taken-branch flush, memory wait and multicycle float occupancy of the ALU stage. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- FP_LATENCY, 4: cycles a float op (FUNCTION 6'b001100) occupies the ALU stage; legal 1..15.
- STALL_CNT_W, 16: width of stall_cycles counter.
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dec_regA  in  5  RegA field of instruction in decode.
- dec_regB  in  5  RegB field of instruction in decode.
- dec_uses_regB  in  1  decode instruction reads RegB.
- alu_valid  in  1  ALU-stage register holds a real instruction.
- alu_MEM_R_EN  in  1  ALU-stage instruction is a load.
- alu_regD  in  5  destination of ALU-stage instruction.
- alu_is_float  in  1  ALU-stage instruction is a float op.
- branch_taken  in  1  ALU stage resolved a taken branch/jump this cycle.
- mem_req  in  1  MEM stage is performing an access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM  out  1 each  pipeline-register load enables (FETCH also gates PC).
- bubble_decode  out  1  IF/ID register loads a NOP instead of fetch output.
- bubble_alu  out  1  ID/ALU register loads a NOP.
- bubble_mem  out  1  ALU/MEM register loads a NOP.
- ctrl_state  out  2  RUN=00, FP_BUSY=01, MEM_WAIT=10.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with EN_REG_FETCH=0.

## Operation
- Conditions (combinational): mem_stall = mem_req & !mem_ready; load_use = alu_valid & alu_MEM_R_EN & alu_regD!=0 & (alu_regD==dec_regA | (dec_uses_regB & alu_regD==dec_regB)); fp_start = alu_valid & alu_is_float & FP_LATENCY>1.
- Priority: mem_stall > FP occupancy > branch_taken > load_use. Lower-priority events are suppressed (not latched); upstream holds them, re-evaluated next cycle.
- mem_stall (any state): all four EN=0, all bubbles 0.
- RUN, fp_start: EN_FETCH/DECODE/ALU=0, EN_MEM=1, bubble_mem=1; next FP_BUSY, fp_cnt<=FP_LATENCY-2.
- FP_BUSY: fp_cnt!=0 -> same outputs as fp_start, fp_cnt decrements; fp_cnt==0 -> all EN=1, no bubbles, next RUN. fp_cnt decrements during mem_stall too (unit keeps computing), floor 0; exit from FP_BUSY only when fp_cnt==0 and !mem_stall.
- RUN, branch_taken: all EN=1, bubble_decode=1, bubble_alu=1 (two wrong-path slots squashed).
- RUN, load_use: EN_FETCH=0, EN_DECODE=0, EN_ALU=1, bubble_alu=1, EN_MEM=1. Exactly one bubble per load-use.
- RUN, nothing: all EN=1, bubbles 0.
- RUN, mem_stall -> MEM_WAIT; MEM_WAIT exits to RUN in the cycle mem_ready=1 (enables already 1 that cycle since mem_stall=0).
- stall_cycles increments each cycle EN_REG_FETCH=0 and reset=0; saturates at all-ones.

## Timing
- Outputs are combinational from state plus inputs; no added latency; state/counters update on rising clk.
- Reset (asynchronous assert, released synchronously by the system): ctrl_state=RUN, fp_cnt=0, stall_cycles=0; while reset=1 all EN=1 and all bubbles=0 regardless of inputs.
- Float op with FP_LATENCY=N stalls upstream exactly N-1 cycles plus any overlapping mem_stall beyond fp_cnt expiry.
- Reset mid-FP_BUSY or mid-MEM_WAIT: abandons immediately to RUN, counters cleared.
- Branch and load_use never coincide with fp_start (single ALU-stage instruction); no arbitration needed between them.

## Configuration
- FP_MULTICYCLE_EN defined: FP_BUSY state, fp_cnt and fp_start logic present as above.
- Undefined: float ops treated as single-cycle; fp_start forced 0, FP_BUSY unreachable, fp_cnt removed; ctrl_state never 01; FP_LATENCY ignored.

## Test plan
- Load r5 in ALU (alu_MEM_R_EN=1, alu_regD=5), dec_regA=5 -> one cycle EN_FETCH=0, EN_DECODE=0, bubble_alu=1; next cycle all EN=1; stall_cycles=1.
- alu_regD=0 load with dec_regA=0 -> no stall, all EN=1.
- Float op with FP_LATENCY=4 -> EN_FETCH/DECODE/ALU=0 and bubble_mem=1 for 3 cycles, ctrl_state 01 for 2 of them, then RUN; with macro undefined -> no stall.
- mem_req=1, mem_ready=0 for 5 cycles then 1 -> all EN=0 five cycles, ctrl_state=10, release on ready cycle, stall_cycles=5.
- branch_taken=1 together with load_use -> bubble_decode=1, bubble_alu=1, all EN=1, no load-use stall.
- Assert reset during FP_BUSY with fp_cnt=2 -> immediately ctrl_state=00, all EN=1, stall_cycles=0.
